// File: rtl/multicycle_control_p.sv
// Multi-cycle instruction controller: FETCH -> DECODE -> EXEC (EX_CYCLES) -> MEM.
// Adds halt, sticky illegal-opcode detection and a retired-instruction counter.
module multicycle_control_p #(
  parameter int OPW       = 4,
  parameter int EX_CYCLES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OPW-1:0]   OpCode,
  input  logic             MemWait,
  input  logic             Halt,
  output logic [1:0]       PCControl,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             Branch,
  output logic             Jump,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic [2:0]       ALU_Select,
  output logic             Stall,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount,
  output logic [1:0]       State
);

  localparam int EXW = (EX_CYCLES > 1) ? $clog2(EX_CYCLES) : 1;
  localparam logic [EXW-1:0]   EX_LOAD = EXW'(EX_CYCLES - 1);
  localparam logic [EXW-1:0]   EX_ONE  = EXW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_MEM    = 2'd3
  } state_t;

  state_t           r_state;
  logic [EXW-1:0]   r_exec_cnt;
  logic             r_mem_op;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic w_legal;
  logic w_mem_done;

  // Only opcodes 0..7 exist; any higher bit set marks the opcode illegal.
  assign w_legal    = ((OpCode >> 3) == '0);
  assign w_mem_done = !(r_mem_op && MemWait);

  // Sequencer state, exec countdown, memory-op flag, sticky illegal flag and retire counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_exec_cnt <= '0;
      r_mem_op   <= 1'b0;
      r_illegal  <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!Halt) r_state <= S_DECODE;
          else       r_state <= S_FETCH;
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state    <= S_EXEC;
            r_exec_cnt <= EX_LOAD;
            r_mem_op   <= (OpCode[2:0] == 3'd3) || (OpCode[2:0] == 3'd4);
          end else begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (r_exec_cnt != '0) r_exec_cnt <= r_exec_cnt - EX_ONE;
          else                  r_state    <= S_MEM;
        end
        S_MEM: begin
          if (w_mem_done) begin
            r_state <= S_FETCH;
            r_count <= r_count + CNT_ONE;
          end else begin
            r_state <= S_MEM;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode; reset forces the bubble/stall pattern regardless of state.
  always_comb begin
    PCControl  = 2'd0;
    Stall      = 1'b1;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    MemtoReg   = 1'b0;
    ALU_Select = 3'd0;
    if (reset) begin
      PCControl = 2'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!Halt) begin
            PCControl = 2'd1;
            Stall     = 1'b0;
          end else begin
            PCControl = 2'd0;
          end
        end
        S_DECODE: begin
          if (w_legal) begin
            case (OpCode[2:0])
              3'd0: begin RegWrite = 1'b1; RegDst = 1'b1; ALU_Select = 3'd0; end
              3'd1: begin RegWrite = 1'b1; RegDst = 1'b1; ALU_Select = 3'd1; end
              3'd2: begin RegWrite = 1'b1; RegDst = 1'b1; ALU_Select = 3'd2; end
              3'd3: begin RegWrite = 1'b1; ALUSrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; end
              3'd4: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
              3'd5: begin ALU_Select = 3'd1; Branch = 1'b1; end
              3'd6: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
              3'd7: begin Jump = 1'b1; end
              default: ALU_Select = 3'd0;
            endcase
          end else begin
            ALU_Select = 3'd0;
          end
        end
        S_EXEC: PCControl = 2'd0;
        S_MEM: begin
          if (w_mem_done) PCControl = 2'd2;
          else            PCControl = 2'd0;
        end
        default: PCControl = 2'd0;
      endcase
    end
  end

  assign State      = r_state;
  assign IllegalOp  = r_illegal;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_multicycle_control_p.sv
// Directed bench: table-driven cycle vectors on an EX_CYCLES=1 instance plus
// hand sequences for async reset, MemWait stretch and counter wrap on a second instance.
module tb_multicycle_control_p;

  logic       clock = 1'b0;
  logic       rst_a, rst_b;
  logic [3:0] op;
  logic       mw, halt;

  logic [1:0]  pc_a, st_a, pc_b, st_b;
  logic [2:0]  alu_a, alu_b;
  logic        rw_a, rd_a, as_a, br_a, j_a, mwr_a, mrd_a, m2r_a, stall_a, ill_a;
  logic        rw_b, rd_b, as_b, br_b, j_b, mwr_b, mrd_b, m2r_b, stall_b, ill_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  always #5 clock = ~clock;

  multicycle_control_p #(.OPW(4), .EX_CYCLES(1), .CNT_W(16)) u_a (
    .clock(clock), .reset(rst_a), .OpCode(op), .MemWait(mw), .Halt(halt),
    .PCControl(pc_a), .RegWrite(rw_a), .RegDst(rd_a), .ALUSrc(as_a), .Branch(br_a),
    .Jump(j_a), .MemWrite(mwr_a), .MemRead(mrd_a), .MemtoReg(m2r_a),
    .ALU_Select(alu_a), .Stall(stall_a), .IllegalOp(ill_a), .InstrCount(cnt_a), .State(st_a)
  );

  multicycle_control_p #(.OPW(4), .EX_CYCLES(3), .CNT_W(2)) u_b (
    .clock(clock), .reset(rst_b), .OpCode(op), .MemWait(mw), .Halt(halt),
    .PCControl(pc_b), .RegWrite(rw_b), .RegDst(rd_b), .ALUSrc(as_b), .Branch(br_b),
    .Jump(j_b), .MemWrite(mwr_b), .MemRead(mrd_b), .MemtoReg(m2r_b),
    .ALU_Select(alu_b), .Stall(stall_b), .IllegalOp(ill_b), .InstrCount(cnt_b), .State(st_b)
  );

  // Packed observation: {State, PCControl, Stall, ctrl8, ALU_Select, IllegalOp}
  logic [16:0] obs_a, obs_b;
  logic [7:0]  ctrl_b;
  assign obs_a  = {st_a, pc_a, stall_a, rw_a, rd_a, as_a, br_a, j_a, mwr_a, mrd_a, m2r_a, alu_a, ill_a};
  assign ctrl_b = {rw_b, rd_b, as_b, br_b, j_b, mwr_b, mrd_b, m2r_b};
  assign obs_b  = {st_b, pc_b, stall_b, ctrl_b, alu_b, ill_b};

  // ctrl8 order: RegWrite RegDst ALUSrc Branch Jump MemWrite MemRead MemtoReg
  localparam logic [7:0] C_RR   = 8'b1100_0000;
  localparam logic [7:0] C_LW   = 8'b1010_0011;
  localparam logic [7:0] C_SW   = 8'b0010_0100;
  localparam logic [7:0] C_BEQ  = 8'b0001_0000;
  localparam logic [7:0] C_ADDI = 8'b1010_0000;
  localparam logic [7:0] C_J    = 8'b0000_1000;
  localparam logic [7:0] C_NONE = 8'b0000_0000;

  typedef struct {
    logic [3:0]  op;
    logic        halt;
    logic        mw;
    logic [16:0] exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [16:0] mk(input logic [1:0] st, input logic [1:0] pc, input logic stall,
                                     input logic [7:0] ctrl, input logic [2:0] alu, input logic ill);
    return {st, pc, stall, ctrl, alu, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic row(input logic [3:0] o, input logic h, input logic m, input logic [1:0] st,
                     input logic [1:0] pc, input logic stall, input logic [7:0] ctrl,
                     input logic [2:0] alu, input logic ill, input logic [15:0] cnt);
    vec_t v;
    v.op = o; v.halt = h; v.mw = m; v.exp = mk(st, pc, stall, ctrl, alu, ill); v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // One plain EX_CYCLES=1 instruction: FETCH, DECODE, EXEC, MEM(CondLoad).
  task automatic instr(input logic [3:0] o, input logic m, input logic h, input logic [7:0] ctrl,
                       input logic [2:0] alu, input logic ill, input logic [15:0] cnt);
    row(o, 1'b0, m, 2'd0, 2'd1, 1'b0, C_NONE, 3'd0, ill, cnt);
    row(o, h,    m, 2'd1, 2'd0, 1'b1, ctrl,   alu,  ill, cnt);
    row(o, h,    m, 2'd2, 2'd0, 1'b1, C_NONE, 3'd0, ill, cnt);
    row(o, h,    m, 2'd3, 2'd2, 1'b1, C_NONE, 3'd0, ill, cnt);
  endtask

  logic [1:0] exp_st_b [8] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] exp_pc_b [8] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; op = 4'd0; mw = 1'b0; halt = 1'b0;

    instr(4'd0, 1'b0, 1'b0, C_RR, 3'd0, 1'b0, 16'd0);
    row(4'd3, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, C_NONE, 3'd0, 1'b0, 16'd1);
    row(4'd3, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, C_LW,   3'd0, 1'b0, 16'd1);
    row(4'd3, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, C_NONE, 3'd0, 1'b0, 16'd1);
    row(4'd3, 1'b0, 1'b1, 2'd3, 2'd0, 1'b1, C_NONE, 3'd0, 1'b0, 16'd1);
    row(4'd3, 1'b0, 1'b0, 2'd3, 2'd2, 1'b1, C_NONE, 3'd0, 1'b0, 16'd1);
    instr(4'd5, 1'b1, 1'b0, C_BEQ,  3'd1, 1'b0, 16'd2);
    instr(4'd4, 1'b0, 1'b0, C_SW,   3'd0, 1'b0, 16'd3);
    instr(4'd1, 1'b0, 1'b0, C_RR,   3'd1, 1'b0, 16'd4);
    instr(4'd2, 1'b0, 1'b0, C_RR,   3'd2, 1'b0, 16'd5);
    instr(4'd6, 1'b0, 1'b0, C_ADDI, 3'd0, 1'b0, 16'd6);
    instr(4'd7, 1'b0, 1'b0, C_J,    3'd0, 1'b0, 16'd7);
    row(4'd9, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, C_NONE, 3'd0, 1'b0, 16'd8);
    row(4'd9, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, C_NONE, 3'd0, 1'b0, 16'd8);
    instr(4'd0, 1'b0, 1'b1, C_RR, 3'd0, 1'b1, 16'd8);
    for (int i = 0; i < 5; i++) row(4'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, C_NONE, 3'd0, 1'b1, 16'd9);
    row(4'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, C_NONE, 3'd0, 1'b1, 16'd9);

    // Reset held: outputs forced even though FETCH with Halt=0 would fetch.
    repeat (2) @(posedge clock);
    #1;
    check("reset_obs", 32'(obs_a), 32'(mk(2'd0, 2'd0, 1'b1, C_NONE, 3'd0, 1'b0)));
    check("reset_cnt", 32'(cnt_a), 32'd0);
    rst_a = 1'b0;

    foreach (tbl[i]) begin
      op = tbl[i].op; halt = tbl[i].halt; mw = tbl[i].mw;
      #1;
      check($sformatf("row%0d_obs", i), 32'(obs_a), 32'(tbl[i].exp));
      check($sformatf("row%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
      @(posedge clock);
      #1;
    end

    // Async reset in the middle of EXEC.
    op = 4'd0; halt = 1'b0; mw = 1'b0;
    @(posedge clock);
    #1;
    check("pre_rst_state", 32'(st_a), 32'd2);
    #2;
    rst_a = 1'b1;
    #1;
    check("midrst_obs", 32'(obs_a), 32'(mk(2'd0, 2'd0, 1'b1, C_NONE, 3'd0, 1'b0)));
    check("midrst_cnt", 32'(cnt_a), 32'd0);
    rst_a = 1'b0;
    #1;
    check("post_rst_fetch", 32'(obs_a), 32'(mk(2'd0, 2'd1, 1'b0, C_NONE, 3'd0, 1'b0)));
    @(posedge clock);
    #1;
    check("post_rst_decode", 32'(st_a), 32'd1);

    // EX_CYCLES=3 lw with two MemWait stall cycles: 8 cycles total.
    rst_b = 1'b0;
    op = 4'd3;
    for (int i = 0; i < 8; i++) begin
      mw = (i < 7);
      #1;
      check($sformatf("lw_st%0d", i), 32'(st_b), 32'(exp_st_b[i]));
      check($sformatf("lw_pc%0d", i), 32'(pc_b), 32'(exp_pc_b[i]));
      check($sformatf("lw_ctrl%0d", i), 32'(ctrl_b), (i == 1) ? 32'(C_LW) : 32'd0);
      @(posedge clock);
      #1;
    end
    check("lw_done_state", 32'(st_b), 32'd0);
    check("lw_done_cnt", 32'(cnt_b), 32'd1);

    // Three more adds (6 cycles each) wrap the 2-bit counter.
    op = 4'd0; mw = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      repeat (6) @(posedge clock);
      #1;
      check($sformatf("wrap_state%0d", k), 32'(st_b), 32'd0);
      check($sformatf("wrap_cnt%0d", k), 32'(cnt_b), 32'((1 + k) % 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
